// File: rtl/ex_hazard_ctrl.sv
// Hazard/forwarding controller: EX/MEM writer scoreboard, operand-forward selects, load-use stall, redirect flush.
// Latency: stall/flush combinational from slots + inputs; forward selects registered, valid the cycle the ID instruction sits in EX.
// Backpressure: a load-use holds IF/ID for exactly one cycle and bubbles EX; a redirect flushes ID and EX and overrides the stall.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   inst_ID_i, valid_ID_i          instruction in ID and its valid flag
//   branch_taken_i                 EX redirect request (ignored when the EX slot is empty)
//   stall_IF_o, stall_ID_o         hold PC / hold IF/ID
//   flush_ID_o, flush_EX_o         bubble into IF/ID / ID/EX
//   forward_sel_A_o/B_o            11 pc+4, 10 alu_out_MEM, 01 dataW_WB, 00 regfile
//   pc_plus_four_selA_o/B_o        pc+4 source: 1 WB, 0 MEM
//   stall_cnt_o, flush_cnt_o       saturating event counters
module ex_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      inst_ID_i,
    input  logic             valid_ID_i,
    input  logic             branch_taken_i,
    output logic             stall_IF_o,
    output logic             stall_ID_o,
    output logic             flush_ID_o,
    output logic             flush_EX_o,
    output logic [1:0]       forward_sel_A_o,
    output logic [1:0]       forward_sel_B_o,
    output logic             pc_plus_four_selA_o,
    output logic             pc_plus_four_selB_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_ALU  = 2'd1;
    localparam logic [1:0] K_LOAD = 2'd2;
    localparam logic [1:0] K_PC4  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The regfile writes through, so a writer in WB is already visible to the
    // ID read; the scoreboard only has to track the EX and MEM slots.
    logic       ex_vld, mem_vld;
    logic [4:0] ex_rd, mem_rd;
    logic [1:0] ex_kind, mem_kind;

    logic [6:0] id_op;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic [1:0] id_kind;
    logic       rs1_used, rs2_used;
    logic       load_use, redirect, id_to_ex;
    logic [2:0] fwd_a, fwd_b;

    // Fields only needed by the datapath, not by hazard detection.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_ID_i[31:25], inst_ID_i[14:12]};

    assign id_op  = inst_ID_i[6:0];
    assign id_rd  = inst_ID_i[11:7];
    assign id_rs1 = inst_ID_i[19:15];
    assign id_rs2 = inst_ID_i[24:20];

    always_comb begin
        id_kind = K_NONE;
        case (id_op)
            OP_R, OP_I, OP_LUI, OP_AUIPC: id_kind = K_ALU;
            OP_LOAD:                      id_kind = K_LOAD;
            OP_JAL, OP_JALR:              id_kind = K_PC4;
            default:                      id_kind = K_NONE;
        endcase
        // Writes to x0 are discarded, so they never produce a hazard.
        if (id_rd == 5'd0) id_kind = K_NONE;
    end

    // x0 always reads as zero from the regfile, so it is treated as unused.
    assign rs1_used = !(id_op == OP_LUI || id_op == OP_AUIPC || id_op == OP_JAL)
                      && (id_rs1 != 5'd0);
    assign rs2_used = (id_op == OP_R || id_op == OP_STORE || id_op == OP_BR)
                      && (id_rs2 != 5'd0);

    assign load_use = valid_ID_i && ex_vld && (ex_kind == K_LOAD) &&
                      ((rs1_used && id_rs1 == ex_rd) || (rs2_used && id_rs2 == ex_rd));
    assign redirect = branch_taken_i && ex_vld;

    assign stall_IF_o = load_use && !redirect;
    assign stall_ID_o = load_use && !redirect;
    assign flush_ID_o = redirect;
    assign flush_EX_o = redirect || load_use;
    assign id_to_ex   = valid_ID_i && !flush_EX_o;

    // Returns {sel[1:0], pc_sel}. The EX slot is checked first so the nearer
    // writer wins; a LOAD in EX falls through, but that case is a load-use
    // and the instruction is bubbled anyway.
    function automatic logic [2:0] fwd_pick(
        input logic       used,
        input logic [4:0] rs,
        input logic       e_vld,
        input logic [4:0] e_rd,
        input logic [1:0] e_kind,
        input logic       m_vld,
        input logic [4:0] m_rd,
        input logic [1:0] m_kind
    );
        if (!used)                                   return 3'b000;
        if (e_vld && e_rd == rs && e_kind == K_ALU)  return 3'b100;
        if (e_vld && e_rd == rs && e_kind == K_PC4)  return 3'b110;
        if (m_vld && m_rd == rs && (m_kind == K_ALU || m_kind == K_LOAD))
                                                     return 3'b010;
        if (m_vld && m_rd == rs && m_kind == K_PC4)  return 3'b111;
        return 3'b000;
    endfunction

    assign fwd_a = fwd_pick(rs1_used, id_rs1, ex_vld, ex_rd, ex_kind, mem_vld, mem_rd, mem_kind);
    assign fwd_b = fwd_pick(rs2_used, id_rs2, ex_vld, ex_rd, ex_kind, mem_vld, mem_rd, mem_kind);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_vld              <= 1'b0;
            ex_rd               <= 5'd0;
            ex_kind             <= K_NONE;
            mem_vld             <= 1'b0;
            mem_rd              <= 5'd0;
            mem_kind            <= K_NONE;
            forward_sel_A_o     <= 2'b00;
            forward_sel_B_o     <= 2'b00;
            pc_plus_four_selA_o <= 1'b0;
            pc_plus_four_selB_o <= 1'b0;
            stall_cnt_o         <= '0;
            flush_cnt_o         <= '0;
        end else begin
            mem_vld  <= ex_vld;
            mem_rd   <= ex_rd;
            mem_kind <= ex_kind;
            ex_vld   <= id_to_ex;
            ex_rd    <= id_rd;
            ex_kind  <= id_to_ex ? id_kind : K_NONE;

            // Bubbles entering EX carry regfile selects.
            if (id_to_ex) begin
                forward_sel_A_o     <= fwd_a[2:1];
                forward_sel_B_o     <= fwd_b[2:1];
                pc_plus_four_selA_o <= fwd_a[0];
                pc_plus_four_selB_o <= fwd_b[0];
            end else begin
                forward_sel_A_o     <= 2'b00;
                forward_sel_B_o     <= 2'b00;
                pc_plus_four_selA_o <= 1'b0;
                pc_plus_four_selB_o <= 1'b0;
            end

            if (stall_IF_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_ONE;
            if (redirect && flush_cnt_o != '1)   flush_cnt_o <= flush_cnt_o + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_STORE = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [31:0]   inst_ID_i;
    logic          valid_ID_i;
    logic          branch_taken_i;
    logic          stall_IF_o, stall_ID_o, flush_ID_o, flush_EX_o;
    logic [1:0]    forward_sel_A_o, forward_sel_B_o;
    logic          pc_plus_four_selA_o, pc_plus_four_selB_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int tests = 0;
    int fails = 0;

    ex_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .inst_ID_i(inst_ID_i), .valid_ID_i(valid_ID_i),
        .branch_taken_i(branch_taken_i), .stall_IF_o(stall_IF_o), .stall_ID_o(stall_ID_o),
        .flush_ID_o(flush_ID_o), .flush_EX_o(flush_EX_o),
        .forward_sel_A_o(forward_sel_A_o), .forward_sel_B_o(forward_sel_B_o),
        .pc_plus_four_selA_o(pc_plus_four_selA_o), .pc_plus_four_selB_o(pc_plus_four_selB_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    // Writer kinds: 0 none, 1 alu result, 2 load, 3 link (pc+4).
    // in_flight[0] is the instruction now in EX, in_flight[1] the one in MEM.
    int m_vld [2];
    int m_rd  [2];
    int m_knd [2];
    int m_sa, m_sb, m_pa, m_pb, m_sc, m_fc;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    function automatic int writer_kind(input logic [31:0] i);
        int k;
        case (i[6:0])
            OP_R, OP_I, OP_LUI, OP_AUIPC: k = 1;
            OP_LOAD:                      k = 2;
            OP_JAL, OP_JALR:              k = 3;
            default:                      k = 0;
        endcase
        if (i[11:7] == 5'd0) k = 0;
        return k;
    endfunction

    function automatic bit reads_rs1(input logic [31:0] i);
        return !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL}) && i[19:15] != 5'd0;
    endfunction

    function automatic bit reads_rs2(input logic [31:0] i);
        return (i[6:0] inside {OP_R, OP_STORE, OP_BR}) && i[24:20] != 5'd0;
    endfunction

    // Nearest in-flight writer of rs decides where the operand comes from:
    // age 0 (EX) -> alu_out_MEM or pc+4 from MEM, age 1 (MEM) -> dataW_WB or pc+4 from WB.
    task automatic source_of(input bit used, input int rs, output int sel, output int pcs);
        sel = 0; pcs = 0;
        if (used) begin
            for (int age = 0; age < 2; age++) begin
                if (m_vld[age] != 0 && m_knd[age] != 0 && m_rd[age] == rs) begin
                    if (m_knd[age] == 3) begin sel = 3; pcs = age; end
                    else if (age == 1)   sel = 1;
                    else if (m_knd[age] == 1) sel = 2;
                    break;
                end
            end
        end
    endtask

    string nm [10];
    initial begin
        nm[0] = "stall_IF"; nm[1] = "stall_ID"; nm[2] = "flush_ID"; nm[3] = "flush_EX";
        nm[4] = "sel_A"; nm[5] = "sel_B"; nm[6] = "pc4_selA"; nm[7] = "pc4_selB";
        nm[8] = "stall_cnt"; nm[9] = "flush_cnt";
    end

    // Every cycle, mid-period, compare every output with the model and then advance it.
    always @(negedge clk_i) begin
        int got [10];
        int exp [10];
        bit lu, rdr, u1, u2;
        int sa, sb, pa, pb;
        got[0] = int'(stall_IF_o); got[1] = int'(stall_ID_o);
        got[2] = int'(flush_ID_o); got[3] = int'(flush_EX_o);
        got[4] = int'(forward_sel_A_o); got[5] = int'(forward_sel_B_o);
        got[6] = int'(pc_plus_four_selA_o); got[7] = int'(pc_plus_four_selB_o);
        got[8] = int'(stall_cnt_o); got[9] = int'(flush_cnt_o);
        if (^{stall_IF_o, stall_ID_o, flush_ID_o, flush_EX_o, forward_sel_A_o, forward_sel_B_o,
              pc_plus_four_selA_o, pc_plus_four_selB_o, stall_cnt_o, flush_cnt_o} === 1'bx)
            got[0] = -1;
        if (!rst_ni) begin
            for (int k = 0; k < 10; k++) exp[k] = 0;
            m_vld[0] = 0; m_vld[1] = 0;
            m_sa = 0; m_sb = 0; m_pa = 0; m_pb = 0; m_sc = 0; m_fc = 0;
        end else begin
            u1  = valid_ID_i && reads_rs1(inst_ID_i);
            u2  = valid_ID_i && reads_rs2(inst_ID_i);
            lu  = m_vld[0] != 0 && m_knd[0] == 2 &&
                  ((u1 && int'(inst_ID_i[19:15]) == m_rd[0]) ||
                   (u2 && int'(inst_ID_i[24:20]) == m_rd[0]));
            rdr = branch_taken_i && m_vld[0] != 0;
            exp[0] = int'(lu && !rdr); exp[1] = int'(lu && !rdr);
            exp[2] = int'(rdr);        exp[3] = int'(rdr || lu);
            exp[4] = m_sa; exp[5] = m_sb; exp[6] = m_pa; exp[7] = m_pb;
            exp[8] = m_sc; exp[9] = m_fc;

            if (lu && !rdr && m_sc < CMAX) m_sc++;
            if (rdr && m_fc < CMAX) m_fc++;
            if (rdr || lu || !valid_ID_i) begin
                m_sa = 0; m_sb = 0; m_pa = 0; m_pb = 0;
                m_vld[1] = m_vld[0]; m_rd[1] = m_rd[0]; m_knd[1] = m_knd[0];
                m_vld[0] = 0; m_knd[0] = 0;
            end else begin
                source_of(u1, int'(inst_ID_i[19:15]), sa, pa);
                source_of(u2, int'(inst_ID_i[24:20]), sb, pb);
                m_sa = sa; m_sb = sb; m_pa = pa; m_pb = pb;
                m_vld[1] = m_vld[0]; m_rd[1] = m_rd[0]; m_knd[1] = m_knd[0];
                m_vld[0] = 1; m_rd[0] = int'(inst_ID_i[11:7]); m_knd[0] = writer_kind(inst_ID_i);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (got[k] !== exp[k]) begin
                fails++;
                $display("FAIL model_%s t=%0t got %0d exp %0d", nm[k], $time, got[k], exp[k]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic [31:0] i, input logic v, input logic br);
        inst_ID_i = i; valid_ID_i = v; branch_taken_i = br;
    endtask

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic issue(input logic [31:0] i);
        set_in(i, 1'b1, 1'b0); tick();
    endtask

    task automatic drain();
        set_in(32'h13, 1'b0, 1'b0); tick(); tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_in(32'h0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({stall_IF_o, flush_ID_o, flush_EX_o, forward_sel_A_o, forward_sel_B_o,
             pc_plus_four_selA_o, pc_plus_four_selB_o, stall_cnt_o, flush_cnt_o} !== '0) begin
            fails++; $display("FAIL reset_outputs got nonzero exp all zero");
        end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_alu_chain();
        drain();
        issue(enc(OP_R, 5, 1, 2)); issue(enc(OP_R, 6, 5, 3));
        tests++;
        if (forward_sel_A_o !== 2'b10 || forward_sel_B_o !== 2'b00) begin
            fails++; $display("FAIL alu_adjacent got A=%b B=%b exp A=10 B=00", forward_sel_A_o, forward_sel_B_o);
        end
        drain();
        issue(enc(OP_R, 5, 1, 2)); issue(32'h13); issue(enc(OP_R, 6, 5, 3));
        tests++;
        if (forward_sel_A_o !== 2'b01 || forward_sel_B_o !== 2'b00) begin
            fails++; $display("FAIL alu_gap1 got A=%b B=%b exp A=01 B=00", forward_sel_A_o, forward_sel_B_o);
        end
    endtask

    task automatic test_load_use();
        int base;
        drain();
        base = m_sc;
        issue(enc(OP_LOAD, 7, 1, 0));
        set_in(enc(OP_R, 8, 7, 7), 1'b1, 1'b0);
        #1;
        tests++;
        if ({stall_IF_o, stall_ID_o, flush_EX_o, flush_ID_o} !== 4'b1110) begin
            fails++; $display("FAIL load_use_stall got %b exp 1110", {stall_IF_o, stall_ID_o, flush_EX_o, flush_ID_o});
        end
        tick();
        tests++;
        if ({stall_IF_o, stall_ID_o, flush_EX_o} !== 3'b000 || forward_sel_A_o !== 2'b00) begin
            fails++; $display("FAIL load_use_second_cycle got stall=%b A=%b exp 000 00",
                              {stall_IF_o, stall_ID_o, flush_EX_o}, forward_sel_A_o);
        end
        tick();
        tests++;
        if (forward_sel_A_o !== 2'b01 || forward_sel_B_o !== 2'b01) begin
            fails++; $display("FAIL load_use_fwd got A=%b B=%b exp 01 01", forward_sel_A_o, forward_sel_B_o);
        end
        tests++;
        if (int'(stall_cnt_o) !== base + 1) begin
            fails++; $display("FAIL load_use_cnt got %0d exp %0d", stall_cnt_o, base + 1);
        end
    endtask

    task automatic test_jal_flush();
        int fb;
        drain();
        fb = m_fc;
        issue(enc(OP_JAL, 1, 0, 0));
        set_in(enc(OP_R, 2, 1, 0), 1'b1, 1'b1);
        #1;
        tests++;
        if ({flush_ID_o, flush_EX_o, stall_IF_o, stall_ID_o} !== 4'b1100) begin
            fails++; $display("FAIL jal_flush got %b exp 1100", {flush_ID_o, flush_EX_o, stall_IF_o, stall_ID_o});
        end
        tick();
        tests++;
        if (int'(flush_cnt_o) !== fb + 1 || forward_sel_A_o !== 2'b00) begin
            fails++; $display("FAIL jal_flush_cnt got cnt=%0d A=%b exp cnt=%0d A=00", flush_cnt_o, forward_sel_A_o, fb + 1);
        end
    endtask

    task automatic test_jal_target();
        drain();
        issue(enc(OP_JAL, 1, 0, 0));
        set_in(enc(OP_R, 9, 9, 9), 1'b1, 1'b1); tick();
        set_in(enc(OP_R, 2, 1, 0), 1'b1, 1'b0); tick();
        tests++;
        if (forward_sel_A_o !== 2'b11 || pc_plus_four_selA_o !== 1'b1 || forward_sel_B_o !== 2'b00) begin
            fails++; $display("FAIL jal_target got A=%b selA=%b B=%b exp 11 1 00",
                              forward_sel_A_o, pc_plus_four_selA_o, forward_sel_B_o);
        end
    endtask

    task automatic test_jalr_adjacent();
        drain();
        issue(enc(OP_JAL, 1, 0, 0)); issue(enc(OP_JALR, 5, 1, 0));
        tests++;
        if (forward_sel_A_o !== 2'b11 || pc_plus_four_selA_o !== 1'b0) begin
            fails++; $display("FAIL jalr_adjacent got A=%b selA=%b exp 11 0", forward_sel_A_o, pc_plus_four_selA_o);
        end
    endtask

    task automatic test_redirect_over_load();
        int sb, fb;
        drain();
        sb = m_sc; fb = m_fc;
        issue(enc(OP_LOAD, 7, 1, 0));
        set_in(enc(OP_R, 8, 7, 7), 1'b1, 1'b1);
        #1;
        tests++;
        if ({flush_ID_o, flush_EX_o, stall_IF_o, stall_ID_o} !== 4'b1100) begin
            fails++; $display("FAIL redirect_vs_load got %b exp 1100", {flush_ID_o, flush_EX_o, stall_IF_o, stall_ID_o});
        end
        tick();
        tests++;
        if (int'(stall_cnt_o) !== sb || int'(flush_cnt_o) !== fb + 1) begin
            fails++; $display("FAIL redirect_vs_load_cnt got s=%0d f=%0d exp s=%0d f=%0d", stall_cnt_o, flush_cnt_o, sb, fb + 1);
        end
    endtask

    task automatic test_x0_unused();
        drain();
        issue(enc(OP_LOAD, 0, 1, 0));
        set_in(enc(OP_R, 3, 0, 0), 1'b1, 1'b0);
        #1;
        tests++;
        if (stall_IF_o !== 1'b0) begin
            fails++; $display("FAIL lw_x0_stall got %b exp 0", stall_IF_o);
        end
        tick();
        tests++;
        if (forward_sel_A_o !== 2'b00 || forward_sel_B_o !== 2'b00) begin
            fails++; $display("FAIL lw_x0_sel got A=%b B=%b exp 00 00", forward_sel_A_o, forward_sel_B_o);
        end
        drain();
        issue(enc(OP_LOAD, 4, 1, 0));
        set_in(enc(OP_LUI, 4, 4, 4), 1'b1, 1'b0);
        #1;
        tests++;
        if (stall_IF_o !== 1'b0 || flush_EX_o !== 1'b0) begin
            fails++; $display("FAIL lui_after_lw got stall=%b flushEX=%b exp 0 0", stall_IF_o, flush_EX_o);
        end
        tick();
        drain();
        issue(enc(OP_R, 9, 1, 1)); issue(enc(OP_STORE, 0, 2, 9));
        tests++;
        if (forward_sel_B_o !== 2'b10 || forward_sel_A_o !== 2'b00) begin
            fails++; $display("FAIL sw_after_add got A=%b B=%b exp 00 10", forward_sel_A_o, forward_sel_B_o);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LUI; ops[3] = OP_AUIPC; ops[4] = OP_LOAD;
        ops[5] = OP_JAL; ops[6] = OP_JALR; ops[7] = OP_STORE; ops[8] = OP_BR; ops[9] = OP_SYS;
        for (int n = 0; n < 500; n++) begin
            set_in(enc(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                   1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) == 0));
            tick();
        end
    endtask

    task automatic test_reset_mid();
        issue(enc(OP_R, 1, 2, 3)); issue(enc(OP_R, 2, 3, 4));
        set_in(enc(OP_R, 3, 1, 2), 1'b1, 1'b0);
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({stall_IF_o, stall_ID_o, flush_ID_o, flush_EX_o, forward_sel_A_o, forward_sel_B_o,
             pc_plus_four_selA_o, pc_plus_four_selB_o, stall_cnt_o, flush_cnt_o} !== '0) begin
            fails++; $display("FAIL reset_mid_outputs got nonzero exp all zero (cnt s=%0d f=%0d)", stall_cnt_o, flush_cnt_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        tests++;
        if (forward_sel_A_o !== 2'b00 || forward_sel_B_o !== 2'b00) begin
            fails++; $display("FAIL reset_first_instr got A=%b B=%b exp 00 00", forward_sel_A_o, forward_sel_B_o);
        end
        drain();
    endtask

    initial begin
        rst_ni = 1'b0;
        set_in(32'h0, 1'b0, 1'b0);
        #2;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_jal_flush();
        test_jal_target();
        test_jalr_adjacent();
        test_redirect_over_load();
        test_x0_unused();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
